// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer slice.
package instr_sequencer_pkg;

    localparam int unsigned WORD_W = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT
    } seq_state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Host/processor handshake bundle between the pins and the sequencer.
interface instr_sequencer_if #(
    parameter int unsigned WIDTH = 12
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] proc_instr;
    logic             proc_start;
    logic [WIDTH-1:0] proc_result;
    logic             proc_done;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             timeout_err;
    logic             busy;

    // Host and processor model side
    modport master (
        output in_data, in_valid, proc_result, proc_done, out_ready,
        input  in_ready, proc_instr, proc_start, out_data, out_valid, timeout_err, busy
    );

    // Sequencer side
    modport slave (
        input  in_data, in_valid, proc_result, proc_done, out_ready,
        output in_ready, proc_instr, proc_start, out_data, out_valid, timeout_err, busy
    );

endinterface

// File: rtl/instr_sequencer_fifo.sv
// Registered synchronous instruction FIFO; head is the oldest word.
module instr_sequencer_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Issues buffered instructions to the processor one at a time and returns
// each result (or an all-ones error word on timeout) to the host.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = WORD_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.slave    bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             start_q;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             in_ready_c;
    logic             push_c;
    logic             pop_c;

    assign in_ready_c = ~fifo_full & ~rst;
    assign push_c     = bus.in_valid & in_ready_c;

    instr_sequencer_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (bus.in_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and next-register values for the issue/wait/return sequence
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        timer_d     = timer_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;
        pop_c       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    instr_d = fifo_head;
                    pop_c   = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.proc_done) begin
                    out_data_d  = bus.proc_result;
                    out_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    out_data_d  = {WIDTH{1'b1}};
                    out_valid_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = S_OUTPUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            start_q     <= 1'b0;
            timer_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            start_q     <= (state_d == S_ISSUE);
            timer_q     <= timer_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.proc_instr  = instr_q;
    assign bus.proc_start  = start_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.timeout_err = err_q;
    assign bus.busy        = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: transaction-level reference model plus directed scenarios and random traffic.
module tb_instr_sequencer;

    localparam int unsigned W  = 12;
    localparam int unsigned D  = 4;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_sequencer_if #(.WIDTH(W)) ifc ();

    instr_sequencer #(
        .WIDTH   (W),
        .DEPTH   (D),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending words plus one job timestamped by its start cycle
    logic [W-1:0] mq[$];
    bit           m_job;
    bit           m_out;
    bit           m_err;
    int           m_start;
    int           cyc = 0;
    logic [W-1:0] m_instr = '0;
    logic [W-1:0] m_word  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_job   = 1'b0;
            m_out   = 1'b0;
            m_err   = 1'b0;
            m_instr = '0;
            m_word  = '0;
        end else begin
            bit push_ok;
            bit idle;
            push_ok = (ifc.in_valid === 1'b1) && (mq.size() < int'(D));
            idle    = !m_job && !m_out;
            if (m_out && ifc.out_ready === 1'b1) m_out = 1'b0;
            if (m_job && cyc > m_start) begin
                if (ifc.proc_done === 1'b1) begin
                    m_out  = 1'b1;
                    m_word = ifc.proc_result;
                    m_job  = 1'b0;
                end else if (cyc - m_start == int'(TO)) begin
                    m_out  = 1'b1;
                    m_word = '1;
                    m_err  = 1'b1;
                    m_job  = 1'b0;
                end
            end
            if (idle && mq.size() > 0) begin
                m_instr = mq.pop_front();
                m_job   = 1'b1;
                m_start = cyc + 1;
            end
            if (push_ok) mq.push_back(ifc.in_data);
        end
        if (clk) cyc++;
    end

    // Every-cycle comparison of all DUT outputs against the model
    always @(negedge clk) begin
        chk("in_ready",    ifc.in_ready,    32'((rst !== 1'b1) && (mq.size() < int'(D))));
        chk("proc_start",  ifc.proc_start,  32'(m_job && (m_start == cyc)));
        chk("proc_instr",  ifc.proc_instr,  32'(m_instr));
        chk("out_valid",   ifc.out_valid,   32'(m_out));
        chk("out_data",    ifc.out_data,    32'(m_word));
        chk("timeout_err", ifc.timeout_err, 32'(m_err));
        chk("busy",        ifc.busy,        32'(m_job || m_out || (mq.size() > 0)));
    end

    // Processor responder: 0 never answers, 1 answers after rdelay wait cycles, 2 random
    int           rmode    = 0;
    int           rdelay   = 1;
    logic [W-1:0] rres     = '0;
    int           cnt      = 0;
    bit           man_done = 1'b0;
    logic [W-1:0] man_res  = '0;

    always @(posedge clk) begin
        #2;
        ifc.proc_result = W'($urandom);
        if (rmode == 1) ifc.proc_result = ifc.proc_instr ^ rres;
        ifc.proc_done = 1'b0;
        if (ifc.proc_start === 1'b1) begin
            cnt = (rmode == 2) ? int'($urandom_range(1, TO + 2)) : rdelay;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && rmode != 0) ifc.proc_done = 1'b1;
        end else if (rmode == 2 && $urandom_range(0, 9) == 0) begin
            ifc.proc_done = 1'b1;
        end
        if (man_done) begin
            ifc.proc_done   = 1'b1;
            ifc.proc_result = man_res;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        ifc.in_valid = 1'b1;
        ifc.in_data  = w;
        step();
        ifc.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Bounded wait for proc_start (on_start=1) or out_valid (on_start=0)
    task automatic wait_for(input string name, input bit on_start, input int limit, output int n);
        n = 0;
        while ((on_start ? ifc.proc_start : ifc.out_valid) !== 1'b1) begin
            if (n >= limit) begin
                checks++;
                errors++;
                $display("FAIL %s actual=no_event required=event within %0d cycles", name, limit);
                return;
            end
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int acc;
        logic [W-1:0] held;
        logic [W-1:0] issued[$];
        logic [W-1:0] results[$];

        rst             = 1'b1;
        ifc.in_valid    = 1'b0;
        ifc.in_data     = '0;
        ifc.out_ready   = 1'b0;
        ifc.proc_done   = 1'b0;
        ifc.proc_result = '0;
        step();
        step();
        chk("reset_in_ready", ifc.in_ready, 0);
        chk("reset_busy", ifc.busy, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", ifc.in_ready, 1);

        // Single instruction, answered three wait cycles after start
        rmode  = 1;
        rdelay = 3;
        rres   = 12'h123 ^ 12'h0A5;
        push_word(12'h0A5);
        wait_for("t1_start", 1'b1, 10, n);
        chk("t1_start_latency", n, 1);
        chk("t1_instr", ifc.proc_instr, 12'h0A5);
        step();
        chk("t1_single_pulse", ifc.proc_start, 0);
        wait_for("t1_out", 1'b0, 20, n);
        chk("t1_out_latency", n, 3);
        chk("t1_out_data", ifc.out_data, 12'h123);
        repeat (3) step();
        chk("t1_out_held", ifc.out_valid, 1);
        chk("t1_err", ifc.timeout_err, 0);
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        chk("t1_out_dropped", ifc.out_valid, 0);

        // Fill: processor silent, six back-to-back pushes, five accepted
        rmode = 0;
        acc   = 0;
        for (int i = 1; i <= 6; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = W'(i);
            if (i == 6) chk("t2_in_ready_6th", ifc.in_ready, 0);
            if (ifc.in_ready === 1'b1) acc++;
            step();
        end
        ifc.in_valid = 1'b0;
        chk("t2_accepted", acc, 5);
        rres     = 12'h800;
        man_res  = 12'h001 ^ 12'h800;
        man_done = 1'b1;
        step();
        man_done      = 1'b0;
        rmode         = 1;
        rdelay        = 2;
        ifc.out_ready = 1'b1;
        issued.delete();
        results.delete();
        issued.push_back(12'h001);
        for (int c = 0; c < 80; c++) begin
            if (ifc.proc_start === 1'b1) issued.push_back(ifc.proc_instr);
            if (ifc.out_valid === 1'b1) results.push_back(ifc.out_data);
            step();
        end
        ifc.out_ready = 1'b0;
        chk("t2_issue_count", issued.size(), 5);
        chk("t2_result_count", results.size(), 5);
        for (int i = 0; i < 5 && i < issued.size() && i < results.size(); i++) begin
            chk("t2_issue_order", issued[i], 32'(i + 1));
            chk("t2_result_order", results[i], 32'((i + 1) ^ 12'h800));
        end

        // proc_done on the last allowed wait cycle wins over the timeout
        rres   = 12'h0F0;
        rdelay = 8;
        push_word(12'h00F);
        wait_for("t5_start", 1'b1, 10, n);
        wait_for("t5_out", 1'b0, 20, n);
        chk("t5_out_latency", n, 9);
        chk("t5_out_data", ifc.out_data, 12'h0FF);
        chk("t5_err", ifc.timeout_err, 0);
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;

        // Timeout after eight wait cycles; a late answer is dropped
        rmode = 0;
        push_word(12'h3C3);
        wait_for("t3_start", 1'b1, 10, n);
        wait_for("t3_out", 1'b0, 20, n);
        chk("t3_out_latency", n, 9);
        chk("t3_out_data", ifc.out_data, 12'hFFF);
        chk("t3_err", ifc.timeout_err, 1);
        step();
        man_res  = 12'h555;
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        step();
        chk("t3_late_ignored", ifc.out_data, 12'hFFF);
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        repeat (2) step();
        chk("t3_err_sticky", ifc.timeout_err, 1);
        chk("t3_idle", ifc.busy, 0);

        // Output back-pressure holds everything until the handshake
        rmode  = 1;
        rdelay = 1;
        rres   = 12'h00A;
        for (int i = 0; i < 3; i++) push_word(W'(12'h210 + i));
        wait_for("t4_out", 1'b0, 20, n);
        held = ifc.out_data;
        chk("t4_first_result", held, 12'h210 ^ 12'h00A);
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            if (ifc.proc_start === 1'b1) acc++;
            if (ifc.out_data !== held) acc += 100;
            step();
        end
        chk("t4_stalled", acc, 0);
        ifc.out_ready = 1'b1;
        step();
        ifc.out_ready = 1'b0;
        chk("t4_no_start_k1", ifc.proc_start, 0);
        step();
        chk("t4_start_k2", ifc.proc_start, 1);
        chk("t4_next_instr", ifc.proc_instr, 12'h211);
        ifc.out_ready = 1'b1;
        repeat (20) step();
        ifc.out_ready = 1'b0;

        // Reset during a wait with words still queued
        rmode = 0;
        for (int i = 0; i < 4; i++) push_word(W'(12'h700 + i));
        step();
        rst = 1'b1;
        #1;
        chk("t6_start", ifc.proc_start, 0);
        chk("t6_instr", ifc.proc_instr, 0);
        chk("t6_out_valid", ifc.out_valid, 0);
        chk("t6_err", ifc.timeout_err, 0);
        chk("t6_busy", ifc.busy, 0);
        chk("t6_in_ready", ifc.in_ready, 0);
        step();
        rst = 1'b0;
        rmode  = 1;
        rdelay = 2;
        push_word(12'h0C0);
        wait_for("t6_start_after", 1'b1, 10, n);
        chk("t6_restart_latency", n, 1);
        chk("t6_restart_instr", ifc.proc_instr, 12'h0C0);
        ifc.out_ready = 1'b1;
        repeat (6) step();

        // Random traffic with occasional resets
        rmode = 2;
        for (int c = 0; c < 2000; c++) begin
            ifc.in_valid  = ($urandom_range(0, 2) == 0);
            ifc.in_data   = W'($urandom);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 399) == 0);
            step();
        end
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (80) step();
        chk("final_idle", ifc.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
